// File: rtl/cs_static_codec.sv
// cs_static_codec: cyclic-shift network-coding encoder followed by a static
// decoder, both fixed at elaboration. Two register stages (enc_o, data_o).
// Optional build macro CS_LOOPBACK_CHECK_EN adds mismatch_o, which compares
// each decoded vector against the data_i vector it came from.
module cs_static_codec #(
    parameter int unsigned K = 5,
    parameter int unsigned M = 3,
    parameter int unsigned L = 11,
    // Systematic default: c(k,k) = 1 for k < M, all others 0
    parameter logic [K-1:0][M-1:0][L-1:0] ENC_COEFF =
        (K*M*L)'({M{{{((M+1)*L-1){1'b0}}, 1'b1}}}),
    // Default: decode symbol m straight from coded symbol m
    parameter logic [M-1:0][K-1:0][L-1:0] DEC_COEFF =
        (M*K*L)'({M{{{((K+1)*L-1){1'b0}}, 1'b1}}})
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [M-1:0][L-2:0] data_i,
    output logic                enc_valid_o,
    output logic [K-1:0][L-2:0] enc_o,
`ifdef CS_LOOPBACK_CHECK_EN
    output logic                mismatch_o,
`endif
    output logic                valid_o,
    output logic [M-1:0][L-2:0] data_o
);

    localparam int unsigned SW = L - 1;

    logic [K-1:0][SW-1:0] enc_c;
    logic [M-1:0][SW-1:0] dec_c;

    // Multiply by x^s in the lifted ring: rotate-left of the L-bit vector
    function automatic logic [L-1:0] rotl(input logic [L-1:0] v, input int unsigned s);
        rotl = (v << s) | (v >> (L - s));
    endfunction

    // Reduce an L-bit ring element back to an (L-1)-bit symbol
    function automatic logic [SW-1:0] project(input logic [L-1:0] r);
        project = r[L-2:0] ^ {SW{r[L-1]}};
    endfunction

    // One coded symbol: XOR of shifted lifted data symbols selected by ENC_COEFF[k]
    function automatic logic [SW-1:0] enc_sym(input int unsigned k,
                                              input logic [M-1:0][SW-1:0] d);
        logic [L-1:0] acc;
        acc = '0;
        for (int unsigned m = 0; m < M; m++) begin
            for (int unsigned s = 0; s < L; s++) begin
                if (ENC_COEFF[k][m][s]) acc ^= rotl({1'b0, d[m]}, s);
            end
        end
        enc_sym = project(acc);
    endfunction

    // One decoded symbol: same network driven by DEC_COEFF[m] over the coded symbols
    function automatic logic [SW-1:0] dec_sym(input int unsigned m,
                                              input logic [K-1:0][SW-1:0] e);
        logic [L-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < K; k++) begin
            for (int unsigned s = 0; s < L; s++) begin
                if (DEC_COEFF[m][k][s]) acc ^= rotl({1'b0, e[k]}, s);
            end
        end
        dec_sym = project(acc);
    endfunction

    // Encoder XOR network, one instance per coded symbol
    for (genvar k = 0; k < K; k++) begin : g_enc
        assign enc_c[k] = enc_sym(k, data_i);
    end

    // Decoder XOR network, one instance per data symbol
    for (genvar m = 0; m < M; m++) begin : g_dec
        assign dec_c[m] = dec_sym(m, enc_o);
    end

    // Stage 1: capture coded symbols on valid_i, hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enc_valid_o <= 1'b0;
            enc_o       <= '0;
        end else begin
            enc_valid_o <= valid_i;
            if (valid_i) enc_o <= enc_c;
        end
    end

    // Stage 2: capture decoded symbols behind enc_valid_o, hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= enc_valid_o;
            if (enc_valid_o) data_o <= dec_c;
        end
    end

`ifdef CS_LOOPBACK_CHECK_EN
    logic [M-1:0][SW-1:0] data_d1;

    // Track the source vector alongside stage 1 and flag a decode that disagrees
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_d1    <= '0;
            mismatch_o <= 1'b0;
        end else begin
            if (valid_i) data_d1 <= data_i;
            mismatch_o <= enc_valid_o && (dec_c != data_d1);
        end
    end
`endif

endmodule

// File: tb/tb_cs_static_codec.sv
// Scoreboard bench for cs_static_codec: a default-parameter instance plus
// four small M/K=1..2 instances exercising individual shift coefficients.
module tb_cs_static_codec;

    typedef logic [9:0] sym_t;

    typedef struct packed {
        logic [2:0][9:0] m;
        sym_t            a_in, a_enc;
        sym_t            b_in, b_enc;
        sym_t            c_in, c_enc;
        logic [1:0][9:0] d_in;
        sym_t            d_enc;
    } vec_t;

    typedef struct packed {
        logic [4:0][9:0] m;
        sym_t            a, b, c, d;
    } enc_exp_t;

    typedef struct packed {
        logic [2:0][9:0] m;
        sym_t            a, b, c;
        logic [1:0][9:0] d;
        logic [4:0]      mis;
    } dec_exp_t;

    logic clk;
    logic rst_n;
    logic valid;
    logic [2:0][9:0] m_din;
    logic [0:0][9:0] a_din, b_din, c_din;
    logic [1:0][9:0] d_din;

    logic            m_env, a_env, b_env, c_env, d_env;
    logic [4:0][9:0] m_enc;
    logic [0:0][9:0] a_enc, b_enc, c_enc, d_enc;
    logic            m_v, a_v, b_v, c_v, d_v;
    logic [2:0][9:0] m_dec;
    logic [0:0][9:0] a_dec, b_dec, c_dec;
    logic [1:0][9:0] d_dec;
`ifdef CS_LOOPBACK_CHECK_EN
    logic            m_mis, a_mis, b_mis, c_mis, d_mis;
`endif

    enc_exp_t enc_q[$];
    dec_exp_t dec_q[$];
    vec_t     vt[6];
    int       n_pass  = 0;
    int       n_total = 0;
    int       dec_cnt = 0;

    cs_static_codec u_main (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(m_din),
        .enc_valid_o(m_env), .enc_o(m_enc),
`ifdef CS_LOOPBACK_CHECK_EN
        .mismatch_o(m_mis),
`endif
        .valid_o(m_v), .data_o(m_dec));

    cs_static_codec #(.K(1), .M(1), .L(11), .ENC_COEFF(11'h002), .DEC_COEFF(11'h400)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(a_din),
        .enc_valid_o(a_env), .enc_o(a_enc),
`ifdef CS_LOOPBACK_CHECK_EN
        .mismatch_o(a_mis),
`endif
        .valid_o(a_v), .data_o(a_dec));

    cs_static_codec #(.K(1), .M(1), .L(11), .ENC_COEFF(11'h400)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(b_din),
        .enc_valid_o(b_env), .enc_o(b_enc),
`ifdef CS_LOOPBACK_CHECK_EN
        .mismatch_o(b_mis),
`endif
        .valid_o(b_v), .data_o(b_dec));

    cs_static_codec #(.K(1), .M(1), .L(11), .ENC_COEFF(11'h003)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(c_din),
        .enc_valid_o(c_env), .enc_o(c_enc),
`ifdef CS_LOOPBACK_CHECK_EN
        .mismatch_o(c_mis),
`endif
        .valid_o(c_v), .data_o(c_dec));

    cs_static_codec #(.K(1), .M(2), .L(11), .ENC_COEFF({11'h001, 11'h001})) u_d (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(d_din),
        .enc_valid_o(d_env), .enc_o(d_enc),
`ifdef CS_LOOPBACK_CHECK_EN
        .mismatch_o(d_mis),
`endif
        .valid_o(d_v), .data_o(d_dec));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [2:0][9:0] m,
                                input sym_t a_in, input sym_t a_e,
                                input sym_t b_in, input sym_t b_e,
                                input sym_t c_in, input sym_t c_e,
                                input logic [1:0][9:0] d_in, input sym_t d_e);
        vec_t v;
        v.m = m; v.a_in = a_in; v.a_enc = a_e; v.b_in = b_in; v.b_enc = b_e;
        v.c_in = c_in; v.c_enc = c_e; v.d_in = d_in; v.d_enc = d_e;
        return v;
    endfunction

    // Drive one vector for one cycle and queue its expected responses
    task automatic issue(input int i);
        enc_exp_t ee;
        dec_exp_t de;
        vec_t     v;
        v = vt[i];
        @(posedge clk);
        #1;
        valid = 1'b1;
        m_din = v.m; a_din = v.a_in; b_din = v.b_in; c_din = v.c_in; d_din = v.d_in;
        ee.m = {20'd0, v.m}; ee.a = v.a_enc; ee.b = v.b_enc; ee.c = v.c_enc; ee.d = v.d_enc;
        de.m = v.m; de.a = v.a_in; de.b = v.b_enc; de.c = v.c_enc; de.d = {10'd0, v.d_enc};
        de.mis = {1'b0, 1'b0, v.b_enc != v.b_in, v.c_enc != v.c_in, {10'd0, v.d_enc} != v.d_in};
        enc_q.push_back(ee);
        dec_q.push_back(de);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    // Monitor: compare every presented output against the scoreboard head
    always @(negedge clk) begin
        enc_exp_t ee;
        dec_exp_t de;
        if (m_env || a_env || b_env || c_env || d_env) begin
            if (enc_q.size() == 0) begin
                chk("enc_unexpected_valid", 64'({m_env, a_env, b_env, c_env, d_env}), 64'(0));
            end else begin
                ee = enc_q.pop_front();
                chk("enc_valid_all", 64'({m_env, a_env, b_env, c_env, d_env}), 64'(5'h1f));
                chk("enc_main", 64'(m_enc), 64'(ee.m));
                chk("enc_a", 64'(a_enc), 64'(ee.a));
                chk("enc_b", 64'(b_enc), 64'(ee.b));
                chk("enc_c", 64'(c_enc), 64'(ee.c));
                chk("enc_d", 64'(d_enc), 64'(ee.d));
            end
        end
        if (m_v || a_v || b_v || c_v || d_v) begin
            if (dec_q.size() == 0) begin
                chk("dec_unexpected_valid", 64'({m_v, a_v, b_v, c_v, d_v}), 64'(0));
            end else begin
                de = dec_q.pop_front();
                dec_cnt++;
                chk("dec_valid_all", 64'({m_v, a_v, b_v, c_v, d_v}), 64'(5'h1f));
                chk("dec_main", 64'(m_dec), 64'(de.m));
                chk("dec_a", 64'(a_dec), 64'(de.a));
                chk("dec_b", 64'(b_dec), 64'(de.b));
                chk("dec_c", 64'(c_dec), 64'(de.c));
                chk("dec_d", 64'(d_dec), 64'(de.d));
`ifdef CS_LOOPBACK_CHECK_EN
                chk("mismatch", 64'({m_mis, a_mis, b_mis, c_mis, d_mis}), 64'(de.mis));
`endif
            end
        end
    end

    initial begin
        //           main data                        a in/enc       b in/enc       c in/enc       d in                  d enc
        vt[0] = mk({10'h2A3, 10'h155, 10'h001}, 10'h001, 10'h002, 10'h001, 10'h3FF, 10'h001, 10'h003, {10'h0F0, 10'h00F}, 10'h0FF);
        vt[1] = mk({10'h3FF, 10'h000, 10'h200}, 10'h155, 10'h2AA, 10'h002, 10'h001, 10'h200, 10'h1FF, {10'h3FF, 10'h001}, 10'h3FE);
        vt[2] = mk({10'h001, 10'h002, 10'h004}, 10'h200, 10'h3FF, 10'h155, 10'h355, 10'h155, 10'h3FF, {10'h2AA, 10'h155}, 10'h3FF);
        vt[3] = mk({10'h123, 10'h321, 10'h0AB}, 10'h3FF, 10'h001, 10'h3FF, 10'h200, 10'h3FF, 10'h3FE, {10'h123, 10'h123}, 10'h000);
        vt[4] = mk({10'h000, 10'h000, 10'h000}, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, {10'h000, 10'h000}, 10'h000);
        vt[5] = mk({10'h1C7, 10'h38E, 10'h071}, 10'h001, 10'h002, 10'h200, 10'h100, 10'h001, 10'h003, {10'h100, 10'h0FF}, 10'h1FF);

        rst_n = 1'b0;
        valid = 1'b0;
        m_din = '0; a_din = '0; b_din = '0; c_din = '0; d_din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_main", 64'({m_env, m_enc, m_v}), 64'(0));
        chk("reset_main_dec", 64'(m_dec), 64'(0));
        chk("reset_small", 64'({a_env, a_enc, a_v, a_dec, d_env, d_enc, d_v, d_dec}), 64'(0));
`ifdef CS_LOOPBACK_CHECK_EN
        chk("reset_mismatch", 64'({m_mis, a_mis, b_mis, c_mis, d_mis}), 64'(0));
`endif
        #2 rst_n = 1'b1;

        // Single vector, then outputs must hold while idle
        issue(0);
        idle(4);
        chk("enc_hold", 64'(m_enc), 64'({20'd0, vt[0].m}));
        chk("dec_hold", 64'(m_dec), 64'(vt[0].m));
        chk("valid_idle", 64'({m_env, m_v}), 64'(0));

        // Five back-to-back vectors, two-cycle gap, one more
        for (int i = 0; i < 5; i++) issue(i);
        idle(2);
        issue(5);
        idle(4);
        chk("stream_pulses", 64'(dec_cnt), 64'(7));

        // Reset with two vectors in flight: outputs clear at once, nothing stale after
        issue(1);
        issue(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        valid = 1'b0;
        enc_q.delete();
        dec_q.delete();
        #1;
        chk("midrst_main", 64'({m_env, m_v}), 64'(0));
        chk("midrst_enc", 64'(m_enc), 64'(0));
        chk("midrst_dec", 64'(m_dec), 64'(0));
        chk("midrst_small", 64'({a_enc, a_dec, d_enc, d_dec}), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        chk("post_rst_pulses", 64'(dec_cnt), 64'(7));
        issue(3);
        idle(4);
        chk("total_pulses", 64'(dec_cnt), 64'(8));
        chk("enc_q_drained", 64'(enc_q.size()), 64'(0));
        chk("dec_q_drained", 64'(dec_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
